// File: rtl/srv_icache_sa.sv
// Set-associative L1 instruction cache for the schoolRISCV fetch path.
// Word-addressed lookup, tree-PLRU replacement, single outstanding line fill,
// and a set-by-set invalidate sequence for fence.i.
module srv_icache_sa #(
  parameter int CACHE_EN   = 1,
  parameter int NWAYS      = 2,
  parameter int NSETS      = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_i,
  input  logic [31:0]                addr_i,
  output logic                       ready_o,
  output logic [31:0]                rdata_o,
  output logic                       rvalid_o,
  input  logic                       flush_i,
  output logic                       ext_req_o,
  output logic [31:0]                ext_addr_o,
  input  logic                       ext_rsp_i,
  input  logic [32*LINE_WORDS-1:0]   ext_data_i
);

  localparam int OFFS_W = $clog2(LINE_WORDS);
  localparam int IDX_W  = (NSETS > 1) ? $clog2(NSETS) : 0;
  localparam int TAG_W  = 32 - OFFS_W - IDX_W;
  localparam int IDX_S  = (IDX_W > 0) ? IDX_W : 1;
  localparam int WAY_W  = (NWAYS > 1) ? $clog2(NWAYS) : 1;
  localparam int unsigned LVL = $clog2(NWAYS);
  localparam int PLRU_W = (NWAYS > 1) ? NWAYS - 1 : 1;
  localparam int NODE_W = (PLRU_W > 1) ? $clog2(PLRU_W) : 1;
  localparam int LINE_W = 32 * LINE_WORDS;

  typedef enum logic [1:0] {S_IDLE, S_MISS, S_FLUSH} state_t;

  state_t                           state_q;
  logic [31:0]                      miss_addr_q;
  logic                             flush_pend_q;
  logic [IDX_S-1:0]                 flush_idx_q;
  logic [NSETS-1:0][NWAYS-1:0]      valid_q;
  logic [NSETS-1:0][PLRU_W-1:0]     plru_q;
  logic [TAG_W-1:0]                 tag_q  [NSETS][NWAYS];
  logic [LINE_W-1:0]                data_q [NSETS][NWAYS];

  logic [31:0]       lk_addr;
  logic [IDX_S-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic [OFFS_W-1:0] lk_off;
  logic [NWAYS-1:0]  hit_vec;
  logic [WAY_W-1:0]  hit_way;
  logic [LINE_W-1:0] hit_line;
  logic [WAY_W-1:0]  victim;
  logic              hit;
  logic [31:0]       hit_word;
  logic [31:0]       fill_word;
  logic              accept;

  // Lowest invalid way first; otherwise follow the PLRU tree from the root.
  function automatic logic [WAY_W-1:0] pick_victim(input logic [NWAYS-1:0] v,
                                                   input logic [PLRU_W-1:0] p);
    logic [WAY_W-1:0]  w;
    logic [NODE_W-1:0] n;
    logic              found;
    w     = '0;
    n     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NWAYS; i++) begin
      if (!found && !v[i]) begin
        w     = WAY_W'(i);
        found = 1'b1;
      end
    end
    if (!found) begin
      for (int unsigned l = 0; l < LVL; l++) begin
        w = (w << 1) | WAY_W'(p[n]);
        n = (n << 1) + NODE_W'(1) + NODE_W'(p[n]);
      end
    end
    return w;
  endfunction

  // Point every node on the path to the accessed way toward the other half.
  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] p,
                                                   input logic [WAY_W-1:0] way);
    logic [PLRU_W-1:0] r;
    logic [WAY_W-1:0]  ws;
    logic [NODE_W-1:0] n;
    logic              dir;
    r  = p;
    ws = way;
    n  = '0;
    for (int unsigned l = 0; l < LVL; l++) begin
      dir  = ws[WAY_W-1];
      r[n] = ~dir;
      n    = (n << 1) + NODE_W'(1) + NODE_W'(dir);
      ws   = ws << 1;
    end
    return r;
  endfunction

  assign lk_addr = (state_q == S_MISS) ? miss_addr_q : addr_i;
  assign lk_idx  = (IDX_W > 0) ? IDX_S'(lk_addr >> OFFS_W) : '0;
  assign lk_tag  = TAG_W'(lk_addr >> (OFFS_W + IDX_W));
  assign lk_off  = OFFS_W'(lk_addr);

  // Tag compare across the indexed set; at most one way can match.
  always_comb begin
    hit_vec  = '0;
    hit_way  = '0;
    hit_line = '0;
    for (int unsigned w = 0; w < NWAYS; w++) begin
      if (CACHE_EN != 0 && valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
        hit_vec[w] = 1'b1;
        hit_way    = WAY_W'(w);
        hit_line   = data_q[lk_idx][w];
      end
    end
  end

  assign hit       = |hit_vec;
  assign victim    = pick_victim(valid_q[lk_idx], plru_q[lk_idx]);
  assign hit_word  = hit_line[{lk_off, 5'b0} +: 32];
  assign fill_word = ext_data_i[{lk_off, 5'b0} +: 32];

  assign ready_o    = (state_q == S_IDLE) & ~flush_i & ~flush_pend_q;
  assign accept     = req_i & ready_o;
  assign ext_req_o  = (state_q == S_MISS);
  assign ext_addr_o = {miss_addr_q[31:OFFS_W], {OFFS_W{1'b0}}};

  // Control FSM plus valid/PLRU state and the registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      miss_addr_q  <= '0;
      flush_pend_q <= 1'b0;
      flush_idx_q  <= '0;
      valid_q      <= '0;
      plru_q       <= '0;
      rvalid_o     <= 1'b0;
      rdata_o      <= '0;
    end else begin
      rvalid_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (flush_i) begin
            state_q     <= S_FLUSH;
            flush_idx_q <= '0;
          end else if (accept) begin
            if (hit) begin
              rdata_o  <= hit_word;
              rvalid_o <= 1'b1;
              if (NWAYS > 1) plru_q[lk_idx] <= plru_touch(plru_q[lk_idx], hit_way);
            end else begin
              miss_addr_q <= addr_i;
              state_q     <= S_MISS;
            end
          end
        end
        S_MISS: begin
          if (flush_i) flush_pend_q <= 1'b1;
          if (ext_rsp_i) begin
            if (CACHE_EN != 0) begin
              valid_q[lk_idx][victim] <= 1'b1;
              if (NWAYS > 1) plru_q[lk_idx] <= plru_touch(plru_q[lk_idx], victim);
            end
            rdata_o  <= fill_word;
            rvalid_o <= 1'b1;
            // A flush arriving in the same cycle as the fill is folded into the pending one.
            if (flush_pend_q || flush_i) begin
              state_q      <= S_FLUSH;
              flush_pend_q <= 1'b0;
              flush_idx_q  <= '0;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_FLUSH: begin
          valid_q[flush_idx_q] <= '0;
          plru_q[flush_idx_q]  <= '0;
          if (flush_idx_q == IDX_S'(NSETS - 1)) state_q <= S_IDLE;
          else flush_idx_q <= flush_idx_q + 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Tag and line storage, written only by a completing refill.
  always_ff @(posedge clk) begin
    if (state_q == S_MISS && ext_rsp_i && CACHE_EN != 0) begin
      tag_q[lk_idx][victim]  <= lk_tag;
      data_q[lk_idx][victim] <= ext_data_i;
    end
  end

endmodule

// File: tb/tb_srv_icache_sa.sv
// Scoreboard bench for srv_icache_sa: random and directed fetches checked
// against an LRU set model and a hashed backing memory.
module tb_srv_icache_sa;

  logic         clk;
  logic         rst_n;
  logic         req_i;
  logic [31:0]  addr_i;
  logic         ready_o;
  logic [31:0]  rdata_o;
  logic         rvalid_o;
  logic         flush_i;
  logic         ext_req_o;
  logic [31:0]  ext_addr_o;
  logic         ext_rsp_i;
  logic [127:0] ext_data_i;

  logic         b_req, b_ready, b_rvalid, b_flush, b_ext_req, b_ext_rsp;
  logic [31:0]  b_addr, b_rdata, b_ext_addr;
  logic [127:0] b_ext_data;

  srv_icache_sa #(.CACHE_EN(1), .NWAYS(2), .NSETS(4), .LINE_WORDS(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .addr_i(addr_i), .ready_o(ready_o),
    .rdata_o(rdata_o), .rvalid_o(rvalid_o), .flush_i(flush_i), .ext_req_o(ext_req_o),
    .ext_addr_o(ext_addr_o), .ext_rsp_i(ext_rsp_i), .ext_data_i(ext_data_i)
  );

  srv_icache_sa #(.CACHE_EN(0), .NWAYS(2), .NSETS(4), .LINE_WORDS(4)) u_byp (
    .clk(clk), .rst_n(rst_n), .req_i(b_req), .addr_i(b_addr), .ready_o(b_ready),
    .rdata_o(b_rdata), .rvalid_o(b_rvalid), .flush_i(b_flush), .ext_req_o(b_ext_req),
    .ext_addr_o(b_ext_addr), .ext_rsp_i(b_ext_rsp), .ext_data_i(b_ext_data)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_fills  = 0;
  int stalls   = 0;
  int rv_cnt   = 0;
  int cyc      = 0;
  logic [31:0] last_fill_addr = '0;
  bit rsp_en     = 1;
  bit force_req  = 0;
  bit force_done;

  logic [31:0] exp_data_q[$];
  logic [31:0] exp_fill_q[$];
  int          rv_cycs[$];
  logic [31:0] mdl [4][$];

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0DE0000;
  endfunction

  function automatic logic [127:0] fill_line(input logic [31:0] base);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = word(base + 32'(k));
    return l;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: each set holds up to two line addresses in recency order.
  function automatic bit mdl_access(input logic [31:0] a);
    logic [31:0] ln;
    int s;
    ln = a >> 2;
    s  = int'(ln % 4);
    for (int i = 0; i < mdl[s].size(); i++) begin
      if (mdl[s][i] == ln) begin
        mdl[s].delete(i);
        mdl[s].push_back(ln);
        return 0;
      end
    end
    if (mdl[s].size() == 2) void'(mdl[s].pop_front());
    mdl[s].push_back(ln);
    return 1;
  endfunction

  function automatic void mdl_clear();
    for (int s = 0; s < 4; s++) mdl[s].delete();
  endfunction

  task automatic issue(input logic [31:0] a);
    int n;
    req_i = 1; addr_i = a; n = 0;
    #1;
    while (!ready_o && n < 300) begin
      @(negedge clk); #1; n++;
    end
    stalls += n;
    if (!ready_o) begin
      chk("issue_timeout", 32'(ready_o), 32'd1);
      req_i = 0;
      return;
    end
    exp_data_q.push_back(word(a));
    if (mdl_access(a)) exp_fill_q.push_back({a[31:2], 2'b00});
    @(posedge clk);
    @(negedge clk);
    req_i = 0;
  endtask

  task automatic flush_pulse();
    flush_i = 1;
    mdl_clear();
    @(posedge clk);
    @(negedge clk);
    flush_i = 0;
  endtask

  task automatic count_not_ready(output int n);
    #1;
    n = 0;
    while (!ready_o && n < 50) begin
      n++; @(negedge clk); #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_data_q.size() != 0 || exp_fill_q.size() != 0) && n < 300) begin
      @(negedge clk); n++;
    end
    chk("drain_timeout", 32'(exp_data_q.size() + exp_fill_q.size()), 32'd0);
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && rvalid_o) begin
      rv_cnt++;
      rv_cycs.push_back(cyc);
      if (exp_data_q.size() == 0) begin
        chk("unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        chk("rdata", rdata_o, exp_data_q.pop_front());
      end
    end
  end

  // Line-fill responder with random latency.
  initial begin
    logic [31:0] e;
    int d;
    ext_rsp_i = 0; ext_data_i = '0; force_done = 0;
    forever begin
      @(negedge clk);
      if (force_req && !force_done) begin
        ext_data_i = fill_line(32'h44);
        ext_rsp_i = 1;
        @(negedge clk);
        ext_rsp_i = 0;
        force_done = 1;
      end else if (rsp_en && rst_n && ext_req_o) begin
        if (exp_fill_q.size() == 0) begin
          chk("unexpected_fill", ext_addr_o, 32'hFFFFFFFF);
        end else begin
          e = exp_fill_q.pop_front();
          chk("ext_addr", ext_addr_o, e);
        end
        n_fills++;
        last_fill_addr = ext_addr_o;
        d = int'($urandom_range(0, 3));
        repeat (d) @(negedge clk);
        chk("ext_addr_stable", ext_addr_o, last_fill_addr);
        ext_data_i = fill_line(ext_addr_o);
        ext_rsp_i = 1;
        @(negedge clk);
        ext_rsp_i = 0;
        chk("fill_rvalid", 32'(rvalid_o), 32'd1);
        chk("ext_req_drop", 32'(ext_req_o), 32'd0);
      end
    end
  end

  logic [31:0] plru_seq [6];
  int          plru_fill [6];

  initial begin
    int f0, s0, t, n, rv0, bad;
    plru_seq  = '{32'h00, 32'h10, 32'h00, 32'h20, 32'h00, 32'h10};
    plru_fill = '{1, 1, 0, 1, 0, 1};
    rst_n = 0; req_i = 0; addr_i = '0; flush_i = 0;
    b_req = 0; b_addr = '0; b_flush = 0; b_ext_rsp = 0; b_ext_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    #1;
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_rvalid", 32'(rvalid_o), 32'd0);
    chk("rst_ext_req", 32'(ext_req_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    @(negedge clk);

    // Cold miss on 0x12: fill of line 0x10, word 2 returned.
    f0 = n_fills;
    issue(32'h12);
    drain();
    chk("cold_fills", 32'(n_fills), 32'(f0 + 1));
    chk("cold_fill_addr", last_fill_addr, 32'h10);

    // Streaming hits: three responses on consecutive cycles, no stall, no fill.
    s0 = stalls; f0 = n_fills;
    issue(32'h10); issue(32'h11); issue(32'h13);
    drain();
    chk("stream_fills", 32'(n_fills), 32'(f0));
    chk("stream_stalls", 32'(stalls), 32'(s0));
    t = rv_cycs.size();
    chk("stream_back2back", 32'(rv_cycs[t-1] - rv_cycs[t-3]), 32'd2);

    // Flush from IDLE, then the same set misses again.
    flush_pulse();
    count_not_ready(n);
    chk("flush_not_ready", 32'(n), 32'd4);
    f0 = n_fills;
    issue(32'h00);
    drain();
    chk("post_flush_miss", 32'(n_fills), 32'(f0 + 1));

    // PLRU eviction in set 0 from an empty cache.
    flush_pulse();
    count_not_ready(n);
    chk("flush2_not_ready", 32'(n), 32'd4);
    for (int i = 0; i < 6; i++) begin
      f0 = n_fills;
      issue(plru_seq[i]);
      drain();
      chk($sformatf("plru_step%0d", i), 32'(n_fills - f0), 32'(plru_fill[i]));
    end
    chk("plru_refetch_addr", last_fill_addr, 32'h10);

    // Flush while a refill is outstanding.
    f0 = n_fills;
    issue(32'h34);
    rv0 = rv_cnt;
    flush_pulse();
    #1;
    n = 0;
    while (rv_cnt == rv0 && n < 100) begin
      @(negedge clk); #1; n++;
    end
    chk("flush_miss_rvalid", 32'(rv_cnt - rv0), 32'd1);
    count_not_ready(n);
    chk("flush_miss_not_ready", 32'(n), 32'd4);
    issue(32'h34);
    drain();
    chk("flush_miss_refetch", 32'(n_fills - f0), 32'd2);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 29) == 0) flush_pulse();
      else issue(32'($urandom_range(0, 63)));
    end
    drain();

    // Bypass instance: every access is a fill.
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      b_req = 1; b_addr = 32'h05;
      #1;
      chk("byp_ready", 32'(b_ready), 32'd1);
      @(negedge clk);
      b_req = 0;
      chk("byp_no_hit", 32'(b_rvalid), 32'd0);
      chk("byp_ext_req", 32'(b_ext_req), 32'd1);
      chk("byp_ext_addr", b_ext_addr, 32'h04);
      b_ext_data = fill_line(32'h04);
      b_ext_rsp = 1;
      @(negedge clk);
      b_ext_rsp = 0;
      chk("byp_rvalid", 32'(b_rvalid), 32'd1);
      chk("byp_rdata", b_rdata, word(32'h05));
    end

    // Reset during a miss: request drops at once, later response is ignored.
    flush_pulse();
    count_not_ready(n);
    rsp_en = 0;
    issue(32'h44);
    chk("rst_miss_pending", 32'(ext_req_o), 32'd1);
    #2 rst_n = 0;
    #1;
    chk("rst_miss_ext_req", 32'(ext_req_o), 32'd0);
    exp_data_q.delete();
    exp_fill_q.delete();
    mdl_clear();
    @(negedge clk);
    rst_n = 1;
    force_req = 1;
    n = 0;
    while (!force_done && n < 20) begin
      @(negedge clk); #1; n++;
    end
    bad = 0;
    repeat (4) begin
      if (rvalid_o) bad++;
      @(negedge clk); #1;
    end
    chk("rst_miss_no_rvalid", 32'(bad), 32'd0);
    chk("rst_miss_force_done", 32'(force_done), 32'd1);

    chk("final_queue_empty", 32'(exp_data_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
